fetch_receive: RTL and testbench

- Stage directly downstream of fetch_issue.
- Pairs each instruction word returned by the instruction memory, one cycle after its read address, with the PC that issued it.
- Buffers responses while decode stalls and squashes wrong-path words on a flush.
- Presents an aligned {instruction, inst_PC, valid} triple to decode.

---
 rtl/fetch_receive.sv | 181 ++++++++++++++++++
 tb/tb_fetch_receive.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_receive.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_receive
//  Description : Fetch receive stage. Pairs each instruction word returned by
//                the instruction memory (one cycle after its read) with the
//                PC that issued it, buffers responses in a 2-entry skid FIFO
//                while decode stalls, squashes wrong-path words on flush and
//                presents a registered {instruction, inst_PC, valid} triple.
//  Options     : FETCH_RECEIVE_STATS_EN adds stall_cycles / squashed_words
//                statistics counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_receive #(
    parameter int                      DATA_WIDTH   = 32,
    parameter int                      ADDRESS_BITS = 32,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0,
    parameter logic [DATA_WIDTH-1:0]   NOP          = 32'h00000013
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDRESS_BITS-1:0] issue_PC,
    input  logic                    i_mem_read_valid,
    input  logic [DATA_WIDTH-1:0]   i_mem_data,
    input  logic                    stall,
    input  logic                    flush,
    output logic                    fetch_ready,
    output logic [DATA_WIDTH-1:0]   instruction,
    output logic [ADDRESS_BITS-1:0] inst_PC,
    output logic                    valid
`ifdef FETCH_RECEIVE_STATS_EN
    ,
    output logic [31:0]             stall_cycles,
    output logic [31:0]             squashed_words
`endif
);

    // Alignment register: PC and valid of the read whose data arrives now
    logic                    pending_v_q,  pending_v_d;
    logic [ADDRESS_BITS-1:0] pending_pc_q, pending_pc_d;

    // Skid FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0]   fifo_data_q [2];
    logic [DATA_WIDTH-1:0]   fifo_data_d [2];
    logic [ADDRESS_BITS-1:0] fifo_pc_q   [2];
    logic [ADDRESS_BITS-1:0] fifo_pc_d   [2];
    logic                    rd_ptr_q, rd_ptr_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic [1:0]              count_q,  count_d;

    // Registered outputs to decode
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic [ADDRESS_BITS-1:0] pc_q,    pc_d;
    logic                    valid_q, valid_d;

    logic                    push;
    logic                    pop;
    logic [2:0]              occupancy;

    // Every in-flight read must be guaranteed a FIFO slot, so count the
    // pending response together with the buffered ones.
    assign occupancy   = {1'b0, count_q} + {2'b00, pending_v_q};
    assign fetch_ready = !reset && (occupancy < 3'd2);

    assign instruction = instr_q;
    assign inst_PC     = pc_q;
    assign valid       = valid_q;

    // Next-state: alignment, FIFO push/pop and output selection
    always_comb begin
        pending_pc_d = issue_PC;
        pending_v_d  = i_mem_read_valid && !flush;
        fifo_data_d  = fifo_data_q;
        fifo_pc_d    = fifo_pc_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        push         = 1'b0;
        pop          = 1'b0;

        if (flush) begin
            // Everything older than the redirect is wrong-path; PC holds.
            instr_d  = NOP;
            valid_d  = 1'b0;
        end else if (!stall) begin
            if (count_q != 2'd0) begin
                // Buffered words drain first to preserve program order.
                instr_d = fifo_data_q[rd_ptr_q];
                pc_d    = fifo_pc_q[rd_ptr_q];
                valid_d = 1'b1;
                pop     = 1'b1;
                push    = pending_v_q;
            end else if (pending_v_q) begin
                instr_d = i_mem_data;
                pc_d    = pending_pc_q;
                valid_d = 1'b1;
            end else begin
                instr_d = NOP;
                valid_d = 1'b0;
            end
        end else begin
            // Outputs hold; park the arriving word. A full FIFO cannot
            // receive a push when upstream honours fetch_ready.
            push = pending_v_q && (count_q != 2'd2);
        end

        if (push) begin
            fifo_data_d[wr_ptr_q] = i_mem_data;
            fifo_pc_d[wr_ptr_q]   = pending_pc_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        if (flush) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control and output state registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_v_q  <= 1'b0;
            pending_pc_q <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            instr_q      <= NOP;
            pc_q         <= RESET_PC;
            valid_q      <= 1'b0;
        end else begin
            pending_v_q  <= pending_v_d;
            pending_pc_q <= pending_pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
        end
    end

    // FIFO payload storage; contents are qualified by count_q so no reset
    always_ff @(posedge clock) begin
        fifo_data_q <= fifo_data_d;
        fifo_pc_q   <= fifo_pc_d;
    end

`ifdef FETCH_RECEIVE_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] squashed_words_q;

    assign stall_cycles   = stall_cycles_q;
    assign squashed_words = squashed_words_q;

    // Statistics: stalled edges and words discarded by flushes (wrapping)
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles_q   <= 32'd0;
            squashed_words_q <= 32'd0;
        end else if (flush) begin
            squashed_words_q <= squashed_words_q + {29'd0, occupancy};
        end else if (stall) begin
            stall_cycles_q   <= stall_cycles_q + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_receive.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_receive
//  Description : Scoreboard bench for fetch_receive. Issued reads are queued
//                with their data; the queue is popped when decode accepts a
//                new output and cleared on flush/reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_receive;

    localparam logic [31:0] C_NOP      = 32'h00000013;
    localparam logic [31:0] C_RESET_PC = 32'h00000000;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [31:0] issue_PC;
    logic        i_mem_read_valid;
    logic [31:0] i_mem_data;
    logic        stall;
    logic        flush;
    logic        fetch_ready;
    logic [31:0] instruction;
    logic [31:0] inst_PC;
    logic        valid;
`ifdef FETCH_RECEIVE_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] squashed_words;
`endif

    fetch_receive #(
        .DATA_WIDTH   (32),
        .ADDRESS_BITS (32),
        .RESET_PC     (C_RESET_PC),
        .NOP          (C_NOP)
    ) u_dut (
        .clock            (clock),
        .reset            (reset),
        .issue_PC         (issue_PC),
        .i_mem_read_valid (i_mem_read_valid),
        .i_mem_data       (i_mem_data),
        .stall            (stall),
        .flush            (flush),
        .fetch_ready      (fetch_ready),
        .instruction      (instruction),
        .inst_PC          (inst_PC),
        .valid            (valid)
`ifdef FETCH_RECEIVE_STATS_EN
        ,
        .stall_cycles     (stall_cycles),
        .squashed_words   (squashed_words)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          checks   = 0;
    int          failures = 0;
    exp_t        sb_q[$];
    logic        prev_rd;
    logic [31:0] prev_data;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic [31:0] exp_stalls;
    logic [31:0] exp_squash;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, update the model, sample 1ns after the edge
    task automatic step(input bit rd, input logic [31:0] pc, input logic [31:0] data,
                        input bit st, input bit fl, input bit rs);
        int   eligible;
        exp_t head;
        reset            = rs;
        stall            = st;
        flush            = fl;
        issue_PC         = pc;
        i_mem_read_valid = rd;
        i_mem_data       = prev_rd ? prev_data : 32'hDEADBEEF;
        prev_rd          = rd;
        prev_data        = data;
        eligible         = sb_q.size();
        if (rs) begin
            sb_q.delete();
        end else if (fl) begin
            exp_squash = exp_squash + sb_q.size();
            sb_q.delete();
        end else if (rd) begin
            sb_q.push_back('{data: data, pc: pc});
        end

        @(posedge clock);
        #1;

        if (rs) begin
            exp_valid  = 1'b0;
            exp_instr  = C_NOP;
            exp_pc     = C_RESET_PC;
            exp_stalls = 32'd0;
            exp_squash = 32'd0;
        end else if (fl) begin
            exp_valid = 1'b0;
            exp_instr = C_NOP;
        end else if (!st) begin
            if (eligible > 0) begin
                head      = sb_q.pop_front();
                exp_valid = 1'b1;
                exp_instr = head.data;
                exp_pc    = head.pc;
            end else begin
                exp_valid = 1'b0;
                exp_instr = C_NOP;
            end
        end else begin
            exp_stalls = exp_stalls + 32'd1;
        end

        check_eq("valid",       {31'd0, valid},       {31'd0, exp_valid});
        check_eq("instruction", instruction,          exp_instr);
        check_eq("inst_PC",     inst_PC,              exp_pc);
        check_eq("fetch_ready", {31'd0, fetch_ready}, {31'd0, (!rs && sb_q.size() < 2)});
`ifdef FETCH_RECEIVE_STATS_EN
        check_eq("stall_cycles",   stall_cycles,   exp_stalls);
        check_eq("squashed_words", squashed_words, exp_squash);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        prev_rd          = 1'b0;
        prev_data        = 32'd0;
        exp_valid        = 1'b0;
        exp_instr        = C_NOP;
        exp_pc           = C_RESET_PC;
        exp_stalls       = 32'd0;
        exp_squash       = 32'd0;
        reset            = 1'b1;
        stall            = 1'b0;
        flush            = 1'b0;
        issue_PC         = 32'd0;
        i_mem_read_valid = 1'b0;
        i_mem_data       = 32'd0;

        // Reset for 3 cycles, then an idle cycle
        repeat (3) step(0, 32'h0, 32'h0, 0, 0, 1);
        step(0, 32'h0, 32'h0, 0, 0, 0);
        check_eq("post_reset_ready", {31'd0, fetch_ready}, 32'd1);
        check_eq("post_reset_instr", instruction, 32'h00000013);

        // Back-to-back reads, no stall
        step(1, 32'h0, 32'hA000_0000, 0, 0, 0);
        step(1, 32'h4, 32'hA000_0001, 0, 0, 0);
        step(1, 32'h8, 32'hA000_0002, 0, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0, 0);
        check_eq("stream_last_pc", inst_PC, 32'h8);
        step(0, 32'h0, 32'h0, 0, 0, 0);

        // Stream stalled for 3 cycles, then drained in order
        step(1, 32'h100, 32'hB000_0000, 0, 0, 0);
        step(1, 32'h104, 32'hB000_0001, 0, 0, 0);
        step(1, 32'h108, 32'hB000_0002, 1, 0, 0);
        step(0, 32'h0,   32'h0,         1, 0, 0);
        step(0, 32'h0,   32'h0,         1, 0, 0);
        check_eq("stall_full_ready", {31'd0, fetch_ready}, 32'd0);
        repeat (3) step(0, 32'h0, 32'h0, 0, 0, 0);

        // Reset with the FIFO full
        step(1, 32'h200, 32'hC000_0000, 1, 0, 0);
        step(1, 32'h204, 32'hC000_0001, 1, 0, 0);
        step(0, 32'h0,   32'h0,         1, 0, 0);
        step(0, 32'h0,   32'h0,         0, 0, 1);
        step(0, 32'h0,   32'h0,         0, 0, 0);
        check_eq("reset_mid_pc", inst_PC, 32'h0);

        // Two idle stall cycles, then count=2 + pending (over-issue), flush
        step(0, 32'h0,   32'h0,         1, 0, 0);
        step(0, 32'h0,   32'h0,         1, 0, 0);
        step(1, 32'h300, 32'hD000_0000, 1, 0, 0);
        step(1, 32'h304, 32'hD000_0001, 1, 0, 0);
        step(1, 32'h308, 32'hD000_0002, 1, 0, 0);
        step(0, 32'h0,   32'h0,         1, 1, 0);
        check_eq("flush_ready", {31'd0, fetch_ready}, 32'd1);
`ifdef FETCH_RECEIVE_STATS_EN
        check_eq("plan_stall_cycles",   stall_cycles,   32'd5);
        check_eq("plan_squashed_words", squashed_words, 32'd3);
`endif
        step(1, 32'h8000, 32'hCAFE_0001, 0, 0, 0);
        step(0, 32'h0,    32'h0,         0, 0, 0);
        check_eq("redirect_pc", inst_PC, 32'h8000);
        step(0, 32'h0,    32'h0,         0, 0, 0);

        // Mixed traffic honouring fetch_ready
        for (int i = 0; i < 60; i++) begin
            bit          r;
            bit          s;
            bit          f;
            logic [31:0] a;
            s = ($urandom_range(0, 2) == 0);
            f = ($urandom_range(0, 16) == 0);
            r = (sb_q.size() < 2) && ($urandom_range(0, 1) == 1);
            a = 32'h1000 + 32'(i * 4);
            step(r, a, $urandom, s, f, 0);
        end
        repeat (4) step(0, 32'h0, 32'h0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
